ifetch_queue: RTL and testbench

- Instruction prefetch stage between a variable-latency instruction memory (req/ack) and the single-cycle core's decode path.
- Fetches sequential words ahead of the core into a small FIFO.
- Presents {inst, inst_pc} with a valid/ready handshake.
- Flushes and restarts on a redirect (branch/jump target) from the core's NPC logic.

---
 rtl/ifetch_queue_pkg.sv | 21 ++
 rtl/ifq_fifo.sv | 100 ++++++++++
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM encodings,
// reset fetch address and the {pc, word} entry format held in the FIFO.
package ifetch_queue_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DROP = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO with a registered head word; flush wins over
// push and the head keeps its last value while the FIFO is empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] TWO_C   = CW'(2'd2);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  head_r;
  logic [W-1:0]  head_nxt_s;
  logic [PW-1:0] rd_next_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == ZERO_C);
  assign count     = count_r;
  assign dout      = head_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_next_s = rd_ptr_r + PTR_ONE;

  // Next head word: the entry behind the popped one, or the incoming word when the FIFO drains or fills from empty.
  always_comb begin
    head_nxt_s = head_r;
    if (flush) begin
      head_nxt_s = head_r;
    end else if (pop_ok_s) begin
      if (count_r >= TWO_C) begin
        head_nxt_s = mem_r[rd_next_s];
      end else if (push_ok_s) begin
        head_nxt_s = din;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (push_ok_s && empty) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_C;
      head_r   <= {W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_C;
      head_r   <= head_nxt_s;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
      head_r <= head_nxt_s;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: single-outstanding req/ack fetcher feeding a
// small FIFO toward decode, with flush-and-restart on core redirects.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [31:0]   im_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  input  logic          inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_nxt_s;
  logic [AW-1:0] drop_addr_r;
  logic [CW-1:0] count_s;
  logic [CW-1:0] post_push_count_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  assign inst_valid        = ~empty_s;
  assign inst              = head_s.word;
  assign inst_pc           = head_s.pc;
  assign pop_s             = inst_valid & inst_ready;
  assign push_s            = (state_r == ST_WAIT) & im_ack & ~redirect;
  assign flush_s           = redirect;
  assign push_entry_s      = '{pc: fetch_pc_r, word: im_rdata};
  assign post_push_count_s = pop_s ? count_s : (count_s + ONE_C);

  // The memory still owns the abandoned address during DROP, so im_addr keeps it until the ack.
  assign im_req  = (state_r == ST_WAIT) | (state_r == ST_DROP);
  assign im_addr = (state_r == ST_DROP) ? drop_addr_r : fetch_pc_r[AW+1:2];

  // Fetch FSM next-state and fetch address.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_nxt_s = word_align(redirect_pc);
        end else if (!full_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_nxt_s = word_align(redirect_pc);
          state_nxt_s    = im_ack ? ST_IDLE : ST_DROP;
        end else if (im_ack) begin
          fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
          state_nxt_s    = (post_push_count_s < DEPTH_C) ? ST_WAIT : ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          fetch_pc_nxt_s = word_align(redirect_pc);
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        state_nxt_s = im_ack ? ST_IDLE : ST_DROP;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        fetch_pc_nxt_s = fetch_pc_r;
      end
    endcase
  end

  // FSM state, fetch PC and held address of a request being drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      fetch_pc_r  <= RESET_PC;
      drop_addr_r <= {AW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      if ((state_r == ST_WAIT) && (state_nxt_s == ST_DROP)) begin
        drop_addr_r <= fetch_pc_r[AW+1:2];
      end else begin
        drop_addr_r <= drop_addr_r;
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: table of memory-latency/ready scenarios
// plus hand-written sequences for full, redirect, wrap and reset corners.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [31:0]   im_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_ready;

  int nchk = 0;
  int nerr = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  logic [31:0] ackq[$];
  logic [63:0] popq[$];

  typedef struct {
    int   lat;
    logic rdy;
    int   cycles;
    int   exp_acks;
    int   exp_pops;
    logic exp_req;
    logic exp_valid;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // Memory model: acks each request after mem_lat idle cycles (0 = same cycle).
  always @(negedge clk) begin
    if (im_req) begin
      if (wait_cnt >= mem_lat) begin
        im_ack   = 1'b1;
        im_rdata = mem_word(im_addr);
        wait_cnt = 0;
      end else begin
        im_ack   = 1'b0;
        im_rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      im_ack   = 1'b0;
      wait_cnt = 0;
    end
  end

  // Log accepted memory transfers and consumed instructions just before each edge.
  always @(negedge clk) begin
    #4;
    if (rst && im_req && im_ack) ackq.push_back({22'd0, im_addr});
    if (rst && inst_valid && inst_ready) popq.push_back({inst_pc, inst});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input int bound, input string name);
    int n = 0;
    while (im_req !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, im_req}, {63'd0, lvl});
  endtask

  task automatic wait_pops(input int cnt, input int bound, input string name);
    int n = 0;
    while (popq.size() < cnt && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(popq.size() >= cnt), 64'd1);
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    @(negedge clk);
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b0;
    mem_lat     = lat;
    repeat (2) @(negedge clk);
    ackq.delete();
    popq.delete();
    inst_ready = rdy;
    rst        = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 10, 9, 8, 1'b1, 1'b1};
    vecs[1] = '{1, 1'b1, 10, 4, 4, 1'b1, 1'b0};
    vecs[2] = '{0, 1'b0, 10, 4, 0, 1'b0, 1'b1};
    vecs[3] = '{2, 1'b1, 12, 3, 3, 1'b1, 1'b0};
    vecs[4] = '{1, 1'b0, 12, 4, 0, 1'b0, 1'b1};

    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    im_ack = 1'b0; im_rdata = 32'd0;
    #1;
    check("rst_req",   {63'd0, im_req},     64'd0);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst",  {32'd0, inst},       64'd0);
    check("rst_pc",    {32'd0, inst_pc},    64'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].lat, vecs[v].rdy);
      repeat (vecs[v].cycles) @(posedge clk);
      #2;
      check($sformatf("v%0d_acks", v), 64'(ackq.size()), 64'(vecs[v].exp_acks));
      check($sformatf("v%0d_pops", v), 64'(popq.size()), 64'(vecs[v].exp_pops));
      check($sformatf("v%0d_req", v), {63'd0, im_req}, {63'd0, vecs[v].exp_req});
      check($sformatf("v%0d_valid", v), {63'd0, inst_valid}, {63'd0, vecs[v].exp_valid});
      for (int i = 0; i < ackq.size(); i++)
        check($sformatf("v%0d_addr%0d", v, i), {32'd0, ackq[i]}, 64'(i));
      for (int i = 0; i < popq.size(); i++)
        check($sformatf("v%0d_inst%0d", v, i), popq[i],
              {32'(4 * i), mem_word(AW'(i))});
    end

    // Full queue with no consumer, then a single pop restarts fetch at word 4.
    do_reset(0, 1'b0);
    repeat (8) @(negedge clk);
    check("full_acks",  64'(ackq.size()), 64'd4);
    check("full_req",   {63'd0, im_req}, 64'd0);
    check("full_head",  {inst_pc, inst}, {32'h0, mem_word(10'd0)});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    wait_req(1'b1, 5, "full_rereq");
    check("full_addr",  {54'd0, im_addr}, 64'd4);
    check("full_npop",  64'(popq.size()), 64'd1);

    // Redirect while a slow request is outstanding: drain it in DROP, then refetch.
    do_reset(3, 1'b1);
    wait_req(1'b1, 5, "drop_req_up");
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_held",  {63'd0, im_req}, 64'd1);
    check("drop_addr0", {54'd0, im_addr}, 64'd0);
    check("drop_novld", {63'd0, inst_valid}, 64'd0);
    wait_req(1'b0, 10, "drop_done");
    check("drop_novld2", {63'd0, inst_valid}, 64'd0);
    wait_req(1'b1, 5, "drop_rereq");
    check("drop_newaddr", {54'd0, im_addr}, 64'h40);
    wait_pops(1, 20, "drop_pop");
    if (popq.size() > 0)
      check("drop_first", popq[0], {32'h0000_0100, mem_word(10'h40)});
    if (ackq.size() > 0)
      check("drop_ack_addr", {32'd0, ackq[0]}, 64'd0);

    // Redirect landing on the ack edge, to the last word so the PC wraps to 0.
    do_reset(1, 1'b1);
    wait_req(1'b1, 5, "coin_req_up");
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("coin_idle",  {63'd0, im_req}, 64'd0);
    check("coin_novld", {63'd0, inst_valid}, 64'd0);
    wait_req(1'b1, 5, "coin_rereq");
    check("coin_addr",  {54'd0, im_addr}, 64'h3FF);
    wait_pops(2, 30, "coin_pops");
    if (popq.size() > 1) begin
      check("coin_first", popq[0], {32'hFFFF_FFFC, mem_word(10'h3FF)});
      check("coin_wrap",  popq[1], {32'h0000_0000, mem_word(10'h000)});
    end

    // Asynchronous reset with two entries queued and a request in flight.
    do_reset(1, 1'b0);
    for (int n = 0; n < 20 && ackq.size() < 2; n++) @(negedge clk);
    check("mid_acks",  64'(ackq.size()), 64'd2);
    check("mid_req",   {63'd0, im_req}, 64'd1);
    check("mid_valid", {63'd0, inst_valid}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req",   {63'd0, im_req}, 64'd0);
    check("mid_rst_valid", {63'd0, inst_valid}, 64'd0);
    check("mid_rst_pc",    {32'd0, inst_pc}, 64'd0);
    @(negedge clk);
    ackq.delete();
    popq.delete();
    inst_ready = 1'b1;
    rst = 1'b1;
    wait_req(1'b1, 5, "mid_rereq");
    check("mid_addr", {54'd0, im_addr}, 64'd0);
    wait_pops(1, 20, "mid_pop");
    if (popq.size() > 0)
      check("mid_first", popq[0], {32'h0, mem_word(10'd0)});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
